machine_cmd_driver: RTL
=======================

// Module: machine_cmd_driver
// PURPOSE
//  Host-side driver for the Machine CPU datapath (Mealy wrapper: 12-bit word in, 25-bit result out).
//  Buffers host commands in a small FIFO and issues at most one per cycle on the machine's 12-bit input.
//  Captures the machine's 25-bit result in the issue cycle and returns it to the host over a valid/ready port.
//  Sits between the host bus and the machine wrapper, in the system1000 clock domain.
// PARAMETERS
//  DEPTH      4       command FIFO entries; power of 2, >= 2
//  IDLE_WORD  12'h000 word driven to the machine on non-issue cycles; must be a CPU no-op
// PORTS
//  system1000       in   1   clock, rising edge
//  system1000_rstn  in   1   reset: asynchronous, active-low
//  enable           in   1   1 = issuing allowed; 0 = hold commands in the FIFO
//  cmd_valid        in   1   host command valid
//  cmd_data         in   12  host command word
//  cmd_ready        out  1   FIFO can accept (= !full)
//  w2               out  12  to machine input
//  m_result         in   25  from machine result (combinational from w2 and machine state)
//  rsp_valid        out  1   response holds a captured result
//  rsp_data         out  25  captured result
//  rsp_ready        in   1   host accepts response
//  busy             out  1   FIFO non-empty or rsp_valid
//  state            out  2   FSM state: 0 IDLE, 1 ISSUE, 2 STALL
// BEHAVIOUR
//  - Reset values: FIFO empty (pointers 0), cmd_ready=1, rsp_valid=0, rsp_data=0, state=IDLE,
//    w2=IDLE_WORD, busy=0. Reset mid-operation discards all queued commands and any pending response.
//  - Push: cmd_valid && cmd_ready writes cmd_data at the tail. Pointers wrap modulo DEPTH.
//    An extra wrap bit distinguishes full from empty.
//  - issue = enable && !empty && (!rsp_valid || rsp_ready). Evaluated combinationally each cycle.
//  - w2 = FIFO head when issue, else IDLE_WORD. Combinational, no register on w2.
//  - On issue, at the clock edge: pop head; rsp_data <= m_result; rsp_valid <= 1.
//    Latency: command accepted in cycle N is presented on w2 at N+1 at the earliest, and its
//    result is on rsp_data at N+2.
//  - No issue and rsp_valid && rsp_ready: rsp_valid <= 0; rsp_data holds its value.
//  - Issue and rsp_ready in the same cycle: old response retires and the new one loads, so
//    back-to-back throughput is 1/cycle.
//  - Push and pop in the same cycle: both take effect and the count is unchanged.
//    A push to an empty FIFO is not issued in the same cycle (no fall-through).
//  - Full: cmd_ready=0 and cmd_data is ignored. Empty: no issue, and w2=IDLE_WORD.
//  - enable deasserted: no issue. A pending response still drains.
//  - The machine advances state every clock. On non-issue cycles its result is not captured.
//  - FSM, registered, next-state priority in order:
//      STALL if !empty && enable && rsp_valid && !rsp_ready;
//      ISSUE if issue;
//      IDLE otherwise.
//    The state output is the registered state of the previous cycle's decision.
//  - Widths: FIFO pointers are $clog2(DEPTH)+1 bits and wrap naturally. No arithmetic on data.
// CONFIGURATION
//  MACHINE_CMD_DRIVER_SEQ_EN
//   - Defined: adds output rsp_seq [15:0], a per-response sequence number.
//     It resets to 0, loads the issue counter on each capture, and the issue counter then
//     increments, wrapping 16'hFFFF -> 16'h0000.
//   - Undefined: rsp_seq port and counter are absent, and behaviour is otherwise identical.
// TESTING
//  - Reset, then push 12'h123 with enable=1 and rsp_ready=1 -> w2=12'h123 one cycle later.
//    rsp_valid=1 the next cycle, with rsp_data equal to m_result sampled in the issue cycle.
//  - Push 4 words with enable=0 -> cmd_ready=0 after the 4th, and a 5th push is ignored.
//    Raise enable -> exactly 4 responses in order, w2=IDLE_WORD afterwards.
//  - rsp_ready=0 with 2 queued -> one response captured, state=STALL, w2=IDLE_WORD, FIFO holds 1.
//    rsp_ready=1 -> second issue in the same cycle as the retire.
//  - Stream 8 words with cmd_valid=1 and rsp_ready=1 -> steady 1 response/cycle, and pointers
//    wrap past DEPTH without loss.
//  - Assert system1000_rstn=0 with 3 queued and rsp_valid=1 -> immediately rsp_valid=0,
//    cmd_ready=1, busy=0, state=IDLE.
//  - SEQ_EN: run 65537 issues -> rsp_seq reads 16'hFFFF on the 65536th response, then 16'h0000.

Source files
------------

// File: rtl/machine_cmd_driver_if.sv
// machine_cmd_driver_if: host command push and response return handshakes
interface machine_cmd_driver_if;
  logic        cmd_valid;
  logic [11:0] cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [24:0] rsp_data;
  logic        rsp_ready;
  modport master (output cmd_valid, cmd_data, rsp_ready, input cmd_ready, rsp_valid, rsp_data);
  modport slave  (input cmd_valid, cmd_data, rsp_ready, output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/machine_cmd_driver.sv
// machine_cmd_driver: FIFO-buffered command issue to the machine, result capture to host
// Optional rsp_seq output enabled by defining MACHINE_CMD_DRIVER_SEQ_EN.
module machine_cmd_driver #(
  parameter int          DEPTH     = 4,
  parameter logic [11:0] IDLE_WORD = 12'h000
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                enable,
  machine_cmd_driver_if.slave host,
  output logic [11:0]         w2,
  input  logic [24:0]         m_result,
  output logic                busy,
  output logic [1:0]          state
`ifdef MACHINE_CMD_DRIVER_SEQ_EN
  ,
  output logic [15:0]         rsp_seq
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, STALL = 2'd2} state_t;
  state_t st;
  logic [11:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, push, issue;
  // Extra pointer MSB tells full (MSBs differ) from empty (equal).
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign host.cmd_ready = !full;
  assign push = host.cmd_valid && !full;
  assign issue = enable && !empty && (!host.rsp_valid || host.rsp_ready);
  assign w2 = issue ? mem[rd_ptr[AW-1:0]] : IDLE_WORD;
  assign busy = !empty || host.rsp_valid;
  assign state = st;
  always_ff @(posedge system1000)
    if (push) mem[wr_ptr[AW-1:0]] <= host.cmd_data;
  always_ff @(posedge system1000 or negedge system1000_rstn)
    if (!system1000_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      host.rsp_valid <= 1'b0;
      host.rsp_data <= '0;
      st <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (issue) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        host.rsp_valid <= 1'b1;
        host.rsp_data <= m_result;
      end else if (host.rsp_ready) host.rsp_valid <= 1'b0;
      st <= (!empty && enable && host.rsp_valid && !host.rsp_ready) ? STALL : issue ? ISSUE : IDLE;
    end
`ifdef MACHINE_CMD_DRIVER_SEQ_EN
  logic [15:0] issue_cnt;
  always_ff @(posedge system1000 or negedge system1000_rstn)
    if (!system1000_rstn) begin
      issue_cnt <= '0;
      rsp_seq <= '0;
    end else if (issue) begin
      rsp_seq <= issue_cnt;
      issue_cnt <= issue_cnt + 16'd1;
    end
`endif
endmodule
